// File: rtl/decode_stage_hz.sv
// Decode stage: instruction decode, register file, load-use hazard detection with
// bubble insertion, EX/WB operand bypass and the ID/EX pipeline register.
module decode_stage_hz #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int unsigned CNT_W    = 16,
  parameter bit          FWD_EN   = 1'b1
) (
  input  logic             i_decode_clk,
  input  logic             i_decode_reset,
  input  logic [XLEN-1:0]  i_decode_pc,
  input  logic [31:0]      i_decode_inst,
  input  logic             i_decode_inst_vld,
  input  logic [XLEN-1:0]  i_decode_rd_data,
  input  logic [4:0]       i_decode_rd_addr,
  input  logic             i_decode_rd_wren,
  input  logic             i_decode_flush,
  input  logic             i_decode_hold,
  input  logic [XLEN-1:0]  i_decode_alu_data_execute,
  input  logic             i_decode_cnt_clr,
  output logic [31:0]      o_decode_inst_ex,
  output logic [XLEN-1:0]  o_decode_pc_ex,
  output logic [XLEN-1:0]  o_decode_rs1_data_ex,
  output logic [XLEN-1:0]  o_decode_rs2_data_ex,
  output logic [XLEN-1:0]  o_decode_imm_out_ex,
  output logic [3:0]       o_decode_alu_op_ex,
  output logic             o_decode_br_un_ex,
  output logic             o_decode_asel_ex,
  output logic             o_decode_bsel_ex,
  output logic             o_decode_lsu_wren_ex,
  output logic [2:0]       o_decode_slt_sl_ex,
  output logic [1:0]       o_decode_wb_sel_ex,
  output logic             o_decode_rd_wren_ex,
  output logic             o_insn_vld_ctrl,
  output logic             o_decode_vld_ex,
  output logic             o_decode_stall_req,
  output logic [4:0]       o_decode_rs1_addr_hazard,
  output logic [4:0]       o_decode_rs2_addr_hazard,
  output logic [CNT_W-1:0] o_decode_bubble_cnt
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;

  assign opcode   = i_decode_inst[6:0];
  assign funct3   = i_decode_inst[14:12];
  assign funct7b5 = i_decode_inst[30];
  assign rs1_addr = i_decode_inst[19:15];
  assign rs2_addr = i_decode_inst[24:20];

  assign o_decode_rs1_addr_hazard = rs1_addr;
  assign o_decode_rs2_addr_hazard = rs2_addr;

  // Immediate formats
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{i_decode_inst[31]}}, i_decode_inst[31:20]};
  assign imm_s = {{20{i_decode_inst[31]}}, i_decode_inst[31:25], i_decode_inst[11:7]};
  assign imm_b = {{19{i_decode_inst[31]}}, i_decode_inst[31], i_decode_inst[7],
                  i_decode_inst[30:25], i_decode_inst[11:8], 1'b0};
  assign imm_u = {i_decode_inst[31:12], 12'd0};
  assign imm_j = {{11{i_decode_inst[31]}}, i_decode_inst[31], i_decode_inst[19:12],
                  i_decode_inst[20], i_decode_inst[30:21], 1'b0};

  // Control decode
  logic [3:0]  alu_op;
  logic        br_un, asel, bsel, lsu_wren, rd_wren, insn_vld;
  logic [2:0]  slt_sl;
  logic [1:0]  wb_sel;
  logic [31:0] imm32;
  logic        rs1_used, rs2_used;
  logic [XLEN-1:0] imm_x;

  // Opcode decode into execute/memory/writeback controls and operand usage.
  // wb_sel: 0 = memory, 1 = ALU, 2 = PC+4, 3 = immediate.
  always_comb begin
    alu_op   = 4'd0;
    br_un    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b1;
    lsu_wren = 1'b0;
    slt_sl   = 3'd0;
    wb_sel   = 2'd1;
    rd_wren  = 1'b0;
    insn_vld = 1'b1;
    imm32    = 32'd0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OpLui: begin
        rd_wren  = 1'b1;
        wb_sel   = 2'd3;
        rs1_used = 1'b0;
        imm32    = imm_u;
      end
      OpAuipc: begin
        rd_wren  = 1'b1;
        asel     = 1'b1;
        rs1_used = 1'b0;
        imm32    = imm_u;
      end
      OpJal: begin
        rd_wren  = 1'b1;
        asel     = 1'b1;
        wb_sel   = 2'd2;
        rs1_used = 1'b0;
        imm32    = imm_j;
      end
      OpJalr: begin
        rd_wren = 1'b1;
        wb_sel  = 2'd2;
        imm32   = imm_i;
      end
      OpBranch: begin
        asel     = 1'b1;
        br_un    = funct3[1];
        rs2_used = 1'b1;
        imm32    = imm_b;
      end
      OpLoad: begin
        rd_wren = 1'b1;
        wb_sel  = 2'd0;
        slt_sl  = funct3;
        imm32   = imm_i;
      end
      OpStore: begin
        lsu_wren = 1'b1;
        slt_sl   = funct3;
        rs2_used = 1'b1;
        imm32    = imm_s;
      end
      OpImm: begin
        rd_wren = 1'b1;
        // funct7[5] only distinguishes SRAI from SRLI among immediate ops
        alu_op  = {(funct3 == 3'b101) & funct7b5, funct3};
        imm32   = imm_i;
      end
      OpReg: begin
        rd_wren  = 1'b1;
        bsel     = 1'b0;
        alu_op   = {funct7b5, funct3};
        rs2_used = 1'b1;
      end
      OpFence, OpSystem: begin
      end
      default: insn_vld = 1'b0;
    endcase
  end

  assign imm_x = XLEN'($signed(imm32));

  // ID/EX state
  logic [31:0]     inst_ex_q;
  logic [XLEN-1:0] pc_ex_q, rs1_ex_q, rs2_ex_q, imm_ex_q;
  logic [3:0]      alu_op_ex_q;
  logic            br_un_ex_q, asel_ex_q, bsel_ex_q, lsu_wren_ex_q, rd_wren_ex_q;
  logic [2:0]      slt_sl_ex_q;
  logic [1:0]      wb_sel_ex_q;
  logic            insn_vld_ex_q, vld_ex_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Hazard detection against the instruction currently in EX
  logic [4:0] ex_rd;
  logic       ex_is_load, load_use, ex_fwd_ok, ex_clear, bubble_ins;

  assign ex_rd      = inst_ex_q[11:7];
  assign ex_is_load = vld_ex_q && (inst_ex_q[6:0] == OpLoad) && (ex_rd != 5'd0);
  assign load_use   = ex_is_load && i_decode_inst_vld &&
                      ((rs1_used && (rs1_addr == ex_rd)) || (rs2_used && (rs2_addr == ex_rd)));
  assign o_decode_stall_req = load_use && !i_decode_flush;

  // A load's result is not ready in EX, so it is never bypassed
  assign ex_fwd_ok  = FWD_EN && vld_ex_q && rd_wren_ex_q && !ex_is_load;
  assign ex_clear   = i_decode_reset || i_decode_flush || (load_use && !i_decode_hold);
  assign bubble_ins = load_use && !i_decode_flush && !i_decode_hold;

  // Register file
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rs1_val, rs2_val;

  // Synchronous writeback; x0 is never written.
  always_ff @(posedge i_decode_clk) begin
    if (i_decode_rd_wren && (i_decode_rd_addr != 5'd0)) begin
      rf_q[i_decode_rd_addr] <= i_decode_rd_data;
    end
  end

  // Operand select: EX bypass, then WB write-through, then regfile.
  always_comb begin
    rs1_val = rf_q[rs1_addr];
    if (rs1_addr == 5'd0) begin
      rs1_val = '0;
    end else if (ex_fwd_ok && (ex_rd == rs1_addr)) begin
      rs1_val = i_decode_alu_data_execute;
    end else if (i_decode_rd_wren && (i_decode_rd_addr == rs1_addr)) begin
      rs1_val = i_decode_rd_data;
    end
    rs2_val = rf_q[rs2_addr];
    if (rs2_addr == 5'd0) begin
      rs2_val = '0;
    end else if (ex_fwd_ok && (ex_rd == rs2_addr)) begin
      rs2_val = i_decode_alu_data_execute;
    end else if (i_decode_rd_wren && (i_decode_rd_addr == rs2_addr)) begin
      rs2_val = i_decode_rd_data;
    end
  end

  // ID/EX register: cleared on reset, flush or bubble; otherwise captures unless held.
  always_ff @(posedge i_decode_clk) begin
    if (ex_clear) begin
      inst_ex_q     <= NOP_INST;
      pc_ex_q       <= '0;
      rs1_ex_q      <= '0;
      rs2_ex_q      <= '0;
      imm_ex_q      <= '0;
      alu_op_ex_q   <= 4'd0;
      br_un_ex_q    <= 1'b0;
      asel_ex_q     <= 1'b0;
      bsel_ex_q     <= 1'b0;
      lsu_wren_ex_q <= 1'b0;
      slt_sl_ex_q   <= 3'd0;
      wb_sel_ex_q   <= 2'd0;
      rd_wren_ex_q  <= 1'b0;
      insn_vld_ex_q <= 1'b1;
      vld_ex_q      <= 1'b0;
    end else if (!i_decode_hold) begin
      inst_ex_q     <= i_decode_inst;
      pc_ex_q       <= i_decode_pc;
      rs1_ex_q      <= rs1_val;
      rs2_ex_q      <= rs2_val;
      imm_ex_q      <= imm_x;
      alu_op_ex_q   <= alu_op;
      br_un_ex_q    <= br_un;
      asel_ex_q     <= asel;
      bsel_ex_q     <= bsel;
      lsu_wren_ex_q <= lsu_wren;
      slt_sl_ex_q   <= slt_sl;
      wb_sel_ex_q   <= wb_sel;
      rd_wren_ex_q  <= rd_wren;
      insn_vld_ex_q <= insn_vld;
      vld_ex_q      <= i_decode_inst_vld;
    end
  end

  // Saturating count of inserted load-use bubbles; clear wins over increment.
  always_ff @(posedge i_decode_clk) begin
    if (i_decode_reset || i_decode_cnt_clr) begin
      bubble_cnt_q <= '0;
    end else if (bubble_ins && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign o_decode_inst_ex     = inst_ex_q;
  assign o_decode_pc_ex       = pc_ex_q;
  assign o_decode_rs1_data_ex = rs1_ex_q;
  assign o_decode_rs2_data_ex = rs2_ex_q;
  assign o_decode_imm_out_ex  = imm_ex_q;
  assign o_decode_alu_op_ex   = alu_op_ex_q;
  assign o_decode_br_un_ex    = br_un_ex_q;
  assign o_decode_asel_ex     = asel_ex_q;
  assign o_decode_bsel_ex     = bsel_ex_q;
  assign o_decode_lsu_wren_ex = lsu_wren_ex_q;
  assign o_decode_slt_sl_ex   = slt_sl_ex_q;
  assign o_decode_wb_sel_ex   = wb_sel_ex_q;
  assign o_decode_rd_wren_ex  = rd_wren_ex_q;
  assign o_insn_vld_ctrl      = insn_vld_ex_q;
  assign o_decode_vld_ex      = vld_ex_q;
  assign o_decode_bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: instance 0 uses defaults, instance 1 has FWD_EN=0 and CNT_W=2.
`timescale 1ns/1ps
module tb_decode_stage_hz;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_R = 7'b0110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst, d_vld, d_wb_wren, d_flush, d_hold, d_clr;
  logic [31:0] d_pc, d_inst, d_wb_data, d_alu;
  logic [4:0]  d_wb_addr;

  logic [31:0] inst_ex [2], pc_ex [2], rs1_ex [2], rs2_ex [2], imm_ex [2];
  logic [3:0]  alu_op [2];
  logic        br_un [2], asel [2], bsel [2], lsu_wren [2], rd_wren [2], insn_vld [2];
  logic        vld_ex [2], stall [2];
  logic [2:0]  slt_sl [2];
  logic [1:0]  wb_sel [2];
  logic [4:0]  hz1 [2], hz2 [2];
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  decode_stage_hz u_dut (
    .i_decode_clk(clk), .i_decode_reset(d_rst), .i_decode_pc(d_pc), .i_decode_inst(d_inst),
    .i_decode_inst_vld(d_vld), .i_decode_rd_data(d_wb_data), .i_decode_rd_addr(d_wb_addr),
    .i_decode_rd_wren(d_wb_wren), .i_decode_flush(d_flush), .i_decode_hold(d_hold),
    .i_decode_alu_data_execute(d_alu), .i_decode_cnt_clr(d_clr),
    .o_decode_inst_ex(inst_ex[0]), .o_decode_pc_ex(pc_ex[0]), .o_decode_rs1_data_ex(rs1_ex[0]),
    .o_decode_rs2_data_ex(rs2_ex[0]), .o_decode_imm_out_ex(imm_ex[0]),
    .o_decode_alu_op_ex(alu_op[0]), .o_decode_br_un_ex(br_un[0]), .o_decode_asel_ex(asel[0]),
    .o_decode_bsel_ex(bsel[0]), .o_decode_lsu_wren_ex(lsu_wren[0]),
    .o_decode_slt_sl_ex(slt_sl[0]), .o_decode_wb_sel_ex(wb_sel[0]),
    .o_decode_rd_wren_ex(rd_wren[0]), .o_insn_vld_ctrl(insn_vld[0]), .o_decode_vld_ex(vld_ex[0]),
    .o_decode_stall_req(stall[0]), .o_decode_rs1_addr_hazard(hz1[0]),
    .o_decode_rs2_addr_hazard(hz2[0]), .o_decode_bubble_cnt(cnt_a)
  );

  decode_stage_hz #(.CNT_W(2), .FWD_EN(1'b0)) u_dut_alt (
    .i_decode_clk(clk), .i_decode_reset(d_rst), .i_decode_pc(d_pc), .i_decode_inst(d_inst),
    .i_decode_inst_vld(d_vld), .i_decode_rd_data(d_wb_data), .i_decode_rd_addr(d_wb_addr),
    .i_decode_rd_wren(d_wb_wren), .i_decode_flush(d_flush), .i_decode_hold(d_hold),
    .i_decode_alu_data_execute(d_alu), .i_decode_cnt_clr(d_clr),
    .o_decode_inst_ex(inst_ex[1]), .o_decode_pc_ex(pc_ex[1]), .o_decode_rs1_data_ex(rs1_ex[1]),
    .o_decode_rs2_data_ex(rs2_ex[1]), .o_decode_imm_out_ex(imm_ex[1]),
    .o_decode_alu_op_ex(alu_op[1]), .o_decode_br_un_ex(br_un[1]), .o_decode_asel_ex(asel[1]),
    .o_decode_bsel_ex(bsel[1]), .o_decode_lsu_wren_ex(lsu_wren[1]),
    .o_decode_slt_sl_ex(slt_sl[1]), .o_decode_wb_sel_ex(wb_sel[1]),
    .o_decode_rd_wren_ex(rd_wren[1]), .o_insn_vld_ctrl(insn_vld[1]), .o_decode_vld_ex(vld_ex[1]),
    .o_decode_stall_req(stall[1]), .o_decode_rs1_addr_hazard(hz1[1]),
    .o_decode_rs2_addr_hazard(hz2[1]), .o_decode_bubble_cnt(cnt_b)
  );

  // Reference model: architectural view of the ID/EX contents and counters
  typedef struct packed {
    logic        vld;
    logic [31:0] inst, pc, rs1, rs2, imm;
    logic        rd_wren, lsu_wren;
  } ex_t;

  ex_t         m_ex [2];
  logic [31:0] m_rf [32];
  int unsigned m_cnt_a, m_cnt_b;
  int          checks = 0;
  int          errs = 0;

  function automatic ex_t cleared();
    ex_t e;
    e = '0;
    e.inst = NOP;
    return e;
  endfunction

  function automatic logic writes_rd(logic [31:0] i);
    return i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_R};
  endfunction

  function automatic logic uses_rs1(logic [31:0] i);
    return !(i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic logic uses_rs2(logic [31:0] i);
    return i[6:0] inside {OP_R, OP_ST, OP_BR};
  endfunction

  function automatic logic [31:0] imm_of(logic [31:0] i);
    case (i[6:0])
      OP_IMM, OP_LD, OP_JALR: return {{20{i[31]}}, i[31:20]};
      OP_ST:  return {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BR:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC: return {i[31:12], 12'd0};
      OP_JAL: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ex_load();
    return m_ex[0].vld && (m_ex[0].inst[6:0] == OP_LD) && (m_ex[0].inst[11:7] != 5'd0);
  endfunction

  function automatic logic load_use();
    logic [4:0] rd;
    rd = m_ex[0].inst[11:7];
    return ex_load() && d_vld && ((uses_rs1(d_inst) && d_inst[19:15] == rd) ||
                                  (uses_rs2(d_inst) && d_inst[24:20] == rd));
  endfunction

  function automatic logic [31:0] operand(logic [4:0] rs, bit fwd);
    if (rs == 5'd0) return 32'd0;
    if (fwd && m_ex[0].vld && m_ex[0].rd_wren && m_ex[0].inst[11:7] == rs && !ex_load())
      return d_alu;
    if (d_wb_wren && d_wb_addr == rs) return d_wb_data;
    return m_rf[rs];
  endfunction

  function automatic logic [31:0] r_type(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, OP_R};
  endfunction

  function automatic logic [31:0] i_type(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  // One clock edge: DUT and model advance together; outputs settle 1ns later.
  task automatic tick();
    ex_t cap [2];
    logic lu;
    lu = load_use();
    for (int k = 0; k < 2; k++) begin
      cap[k].vld      = d_vld;
      cap[k].inst     = d_inst;
      cap[k].pc       = d_pc;
      cap[k].rs1      = operand(d_inst[19:15], k == 0);
      cap[k].rs2      = operand(d_inst[24:20], k == 0);
      cap[k].imm      = imm_of(d_inst);
      cap[k].rd_wren  = writes_rd(d_inst);
      cap[k].lsu_wren = (d_inst[6:0] == OP_ST);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (d_rst || d_flush || (lu && !d_hold)) m_ex[k] = cleared();
      else if (!d_hold) m_ex[k] = cap[k];
    end
    if (d_rst || d_clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (lu && !d_flush && !d_hold) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    if (d_wb_wren && d_wb_addr != 5'd0) m_rf[d_wb_addr] = d_wb_data;
    #1;
  endtask

  task automatic idle();
    d_rst = 0; d_flush = 0; d_hold = 0; d_clr = 0; d_wb_wren = 0;
    d_wb_addr = 0; d_wb_data = 0; d_alu = 0;
  endtask

  task automatic test_reset();
    idle();
    d_rst = 1; d_inst = NOP; d_vld = 0; d_pc = 0;
    tick(); tick();
    d_rst = 0;
    for (int r = 1; r < 32; r++) begin
      d_wb_wren = 1; d_wb_addr = 5'(r); d_wb_data = $urandom;
      tick();
    end
    d_wb_wren = 0;
    d_vld = 1;
    d_inst = i_type(12'd0, 5'd1, 3'b010, 5'd5, OP_LD); tick();
    d_inst = r_type(5'd6, 5'd5, 5'd2); tick();
    d_pc = 32'h1234; tick();
    if (vld_ex[0] !== 1'b1 || cnt_a !== 16'd1) begin
      errs++; $display("FAIL reset_prefill: vld=%b cnt=%0d expected vld=1 cnt=1", vld_ex[0], cnt_a);
    end
    checks++;
    d_rst = 1; d_inst = r_type(5'd9, 5'd1, 5'd2); tick();
    d_rst = 0;
    for (int k = 0; k < 2; k++) begin
      if (inst_ex[k] !== NOP || pc_ex[k] !== 0 || rs1_ex[k] !== 0 || rs2_ex[k] !== 0 ||
          imm_ex[k] !== 0) begin
        errs++;
        $display("FAIL reset_data[%0d]: inst=%h pc=%h rs1=%h rs2=%h imm=%h expected 00000013/0",
                 k, inst_ex[k], pc_ex[k], rs1_ex[k], rs2_ex[k], imm_ex[k]);
      end
      checks++;
      if ({alu_op[k], br_un[k], asel[k], bsel[k], lsu_wren[k], slt_sl[k], wb_sel[k],
           rd_wren[k]} !== 14'd0 || vld_ex[k] !== 1'b0 || insn_vld[k] !== 1'b1) begin
        errs++;
        $display("FAIL reset_ctrl[%0d]: alu=%h wb=%h rdw=%b vld=%b insn_vld=%b expected 0/0/0/0/1",
                 k, alu_op[k], wb_sel[k], rd_wren[k], vld_ex[k], insn_vld[k]);
      end
      checks++;
    end
    if (cnt_a !== 16'd0 || cnt_b !== 2'd0) begin
      errs++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt_a, cnt_b);
    end
    checks++;
  endtask

  task automatic test_load_use();
    idle(); d_vld = 1; d_pc = 32'h40;
    d_inst = i_type(12'd0, 5'd1, 3'b010, 5'd5, OP_LD); tick();
    d_inst = r_type(5'd6, 5'd5, 5'd2); d_pc = 32'h44; #1;
    if (stall[0] !== 1'b1) begin errs++; $display("FAIL lu_stall: got %b expected 1", stall[0]); end
    checks++;
    tick();
    if (vld_ex[0] !== 1'b0 || inst_ex[0] !== NOP || cnt_a !== 16'd1) begin
      errs++; $display("FAIL lu_bubble: vld=%b inst=%h cnt=%0d expected 0/00000013/1",
                       vld_ex[0], inst_ex[0], cnt_a);
    end
    checks++;
    if (stall[0] !== 1'b0) begin errs++; $display("FAIL lu_stall_once: got %b expected 0", stall[0]); end
    checks++;
    tick();
    if (vld_ex[0] !== 1'b1 || inst_ex[0] !== r_type(5'd6, 5'd5, 5'd2) || pc_ex[0] !== 32'h44 ||
        rs1_ex[0] !== m_rf[5] || rs2_ex[0] !== m_rf[2]) begin
      errs++; $display("FAIL lu_capture: vld=%b inst=%h rs1=%h rs2=%h expected 1/%h/%h/%h",
                       vld_ex[0], inst_ex[0], rs1_ex[0], rs2_ex[0], r_type(5'd6, 5'd5, 5'd2),
                       m_rf[5], m_rf[2]);
    end
    checks++;
  endtask

  task automatic test_ex_bypass();
    idle(); d_vld = 1;
    d_wb_wren = 1; d_wb_addr = 5'd7; d_wb_data = 0; d_inst = NOP; tick();
    d_wb_wren = 0;
    d_inst = i_type(12'd9, 5'd0, 3'b000, 5'd7, OP_IMM); tick();
    d_inst = r_type(5'd8, 5'd7, 5'd7); d_alu = 32'd9; tick();
    if (rs1_ex[0] !== 32'd9 || rs2_ex[0] !== 32'd9) begin
      errs++; $display("FAIL ex_fwd_on: got %h/%h expected 9/9", rs1_ex[0], rs2_ex[0]);
    end
    checks++;
    if (rs1_ex[1] !== 32'd0 || rs2_ex[1] !== 32'd0) begin
      errs++; $display("FAIL ex_fwd_off: got %h/%h expected 0/0", rs1_ex[1], rs2_ex[1]);
    end
    checks++;
    // EX result outranks a simultaneous WB write of the same register
    d_inst = r_type(5'd9, 5'd8, 5'd0); d_alu = 32'hABC;
    d_wb_wren = 1; d_wb_addr = 5'd8; d_wb_data = 32'h55; tick();
    d_wb_wren = 0;
    if (rs1_ex[0] !== 32'hABC || rs1_ex[1] !== 32'h55) begin
      errs++; $display("FAIL ex_over_wb: got %h/%h expected abc/55", rs1_ex[0], rs1_ex[1]);
    end
    checks++;
  endtask

  task automatic test_wb_bypass();
    idle(); d_vld = 1;
    d_inst = r_type(5'd10, 5'd3, 5'd0);
    d_wb_wren = 1; d_wb_addr = 5'd3; d_wb_data = 32'hDEADBEEF; tick();
    if (rs1_ex[0] !== 32'hDEADBEEF || rs1_ex[1] !== 32'hDEADBEEF) begin
      errs++; $display("FAIL wb_through: got %h/%h expected deadbeef", rs1_ex[0], rs1_ex[1]);
    end
    checks++;
    d_inst = r_type(5'd11, 5'd0, 5'd0); d_wb_addr = 5'd0; d_wb_data = 32'd5; tick();
    if (rs1_ex[0] !== 32'd0 || rs2_ex[0] !== 32'd0) begin
      errs++; $display("FAIL wb_x0: got %h/%h expected 0/0", rs1_ex[0], rs2_ex[0]);
    end
    checks++;
    d_wb_wren = 0; d_inst = r_type(5'd12, 5'd3, 5'd3); tick();
    if (rs1_ex[0] !== 32'hDEADBEEF || rs2_ex[1] !== 32'hDEADBEEF) begin
      errs++; $display("FAIL rf_write: got %h/%h expected deadbeef", rs1_ex[0], rs2_ex[1]);
    end
    checks++;
  endtask

  task automatic test_hold_flush();
    logic [31:0] h_inst, h_rs1, h_rs2;
    idle(); d_vld = 1;
    h_inst = r_type(5'd13, 5'd1, 5'd2); h_rs1 = m_rf[1]; h_rs2 = m_rf[2];
    d_inst = h_inst; d_pc = 32'h100; tick();
    d_hold = 1;
    for (int c = 0; c < 3; c++) begin
      d_inst = r_type(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
      d_pc = $urandom; d_alu = $urandom; d_vld = 1'($urandom_range(0, 1));
      tick();
      if (inst_ex[0] !== h_inst || pc_ex[0] !== 32'h100 || rs1_ex[0] !== h_rs1 ||
          rs2_ex[0] !== h_rs2 || vld_ex[0] !== 1'b1 || rd_wren[0] !== 1'b1) begin
        errs++; $display("FAIL hold_%0d: inst=%h pc=%h rs1=%h vld=%b expected %h/100/%h/1",
                         c, inst_ex[0], pc_ex[0], rs1_ex[0], vld_ex[0], h_inst, h_rs1);
      end
      checks++;
    end
    // stall together with hold: ID/EX keeps the load, counter untouched
    d_hold = 0; d_vld = 1; d_inst = i_type(12'd4, 5'd1, 3'b010, 5'd5, OP_LD); tick();
    d_hold = 1; d_inst = r_type(5'd6, 5'd5, 5'd5); #1;
    if (stall[0] !== 1'b1) begin errs++; $display("FAIL hold_stall: got %b expected 1", stall[0]); end
    checks++;
    tick();
    if (inst_ex[0] !== i_type(12'd4, 5'd1, 3'b010, 5'd5, OP_LD) || cnt_a !== 16'(m_cnt_a) ||
        imm_ex[0] !== 32'd4) begin
      errs++; $display("FAIL hold_stall_keep: inst=%h cnt=%0d expected load/%0d",
                       inst_ex[0], cnt_a, m_cnt_a);
    end
    checks++;
    // flush together with load_use: plain clear, no stall, no count
    d_hold = 0; d_flush = 1; #1;
    if (stall[0] !== 1'b0) begin errs++; $display("FAIL flush_stall: got %b expected 0", stall[0]); end
    checks++;
    tick();
    if (inst_ex[0] !== NOP || vld_ex[0] !== 1'b0 || cnt_a !== 16'(m_cnt_a)) begin
      errs++; $display("FAIL flush_clear: inst=%h vld=%b cnt=%0d expected 00000013/0/%0d",
                       inst_ex[0], vld_ex[0], cnt_a, m_cnt_a);
    end
    checks++;
    d_flush = 0;
  endtask

  task automatic test_counter_sat();
    int exp_b [5] = '{1, 2, 3, 3, 3};
    idle(); d_vld = 1; d_inst = NOP; d_clr = 1; tick();
    d_clr = 0;
    if (cnt_a !== 16'd0 || cnt_b !== 2'd0) begin
      errs++; $display("FAIL cnt_clr: got %0d/%0d expected 0/0", cnt_a, cnt_b);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      d_inst = i_type(12'd0, 5'd1, 3'b010, 5'd5, OP_LD); tick();
      d_inst = r_type(5'd6, 5'd5, 5'd5); tick();
      if (cnt_b !== 2'(exp_b[i]) || cnt_a !== 16'(i + 1)) begin
        errs++; $display("FAIL cnt_sat_%0d: got %0d/%0d expected %0d/%0d",
                         i, cnt_a, cnt_b, i + 1, exp_b[i]);
      end
      checks++;
    end
    d_inst = i_type(12'd0, 5'd1, 3'b010, 5'd5, OP_LD); tick();
    d_inst = r_type(5'd6, 5'd5, 5'd5); d_clr = 1; tick();
    d_clr = 0;
    if (cnt_a !== 16'd0 || cnt_b !== 2'd0 || vld_ex[0] !== 1'b0) begin
      errs++; $display("FAIL cnt_clr_wins: got %0d/%0d vld=%b expected 0/0/0", cnt_a, cnt_b, vld_ex[0]);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_R};
    logic [31:0] ri;
    logic exp_stall;
    for (int c = 0; c < 400; c++) begin
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(0, 8)];
      ri[11:7] = 5'($urandom_range(0, 3));
      ri[19:15] = 5'($urandom_range(0, 3));
      ri[24:20] = 5'($urandom_range(0, 3));
      d_inst = ri; d_pc = $urandom; d_vld = ($urandom_range(0, 7) != 0); d_alu = $urandom;
      d_wb_wren = 1'($urandom_range(0, 1)); d_wb_addr = 5'($urandom_range(0, 3)); d_wb_data = $urandom;
      d_flush = ($urandom_range(0, 9) == 0); d_hold = ($urandom_range(0, 6) == 0);
      d_clr = ($urandom_range(0, 19) == 0); d_rst = ($urandom_range(0, 49) == 0);
      #1;
      exp_stall = load_use() && !d_flush;
      for (int k = 0; k < 2; k++) begin
        if (stall[k] !== exp_stall || hz1[k] !== ri[19:15] || hz2[k] !== ri[24:20]) begin
          errs++; $display("FAIL rnd_hazard[%0d] c=%0d: stall=%b hz=%0d/%0d expected %b/%0d/%0d",
                           k, c, stall[k], hz1[k], hz2[k], exp_stall, ri[19:15], ri[24:20]);
        end
        checks++;
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        if (vld_ex[k] !== m_ex[k].vld || inst_ex[k] !== m_ex[k].inst || pc_ex[k] !== m_ex[k].pc) begin
          errs++; $display("FAIL rnd_ex[%0d] c=%0d: vld=%b inst=%h pc=%h expected %b/%h/%h", k, c,
                           vld_ex[k], inst_ex[k], pc_ex[k], m_ex[k].vld, m_ex[k].inst, m_ex[k].pc);
        end
        checks++;
        if (rs1_ex[k] !== m_ex[k].rs1 || rs2_ex[k] !== m_ex[k].rs2 || imm_ex[k] !== m_ex[k].imm) begin
          errs++; $display("FAIL rnd_ops[%0d] c=%0d: rs1=%h rs2=%h imm=%h expected %h/%h/%h", k, c,
                           rs1_ex[k], rs2_ex[k], imm_ex[k], m_ex[k].rs1, m_ex[k].rs2, m_ex[k].imm);
        end
        checks++;
        if (rd_wren[k] !== m_ex[k].rd_wren || lsu_wren[k] !== m_ex[k].lsu_wren ||
            insn_vld[k] !== 1'b1) begin
          errs++; $display("FAIL rnd_ctrl[%0d] c=%0d: rdw=%b lsw=%b iv=%b expected %b/%b/1", k, c,
                           rd_wren[k], lsu_wren[k], insn_vld[k], m_ex[k].rd_wren, m_ex[k].lsu_wren);
        end
        checks++;
      end
      if (cnt_a !== 16'(m_cnt_a) || cnt_b !== 2'(m_cnt_b)) begin
        errs++; $display("FAIL rnd_cnt c=%0d: got %0d/%0d expected %0d/%0d",
                         c, cnt_a, cnt_b, m_cnt_a, m_cnt_b);
      end
      checks++;
    end
    idle();
  endtask

  initial begin
    m_ex[0] = cleared(); m_ex[1] = cleared();
    m_cnt_a = 0; m_cnt_b = 0;
    for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
    d_pc = 0; d_inst = NOP; d_vld = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_ex_bypass();
    test_wb_bypass();
    test_hold_flush();
    test_counter_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
Parametrised successor to the decode stage: decode, register read and the ID/EX pipeline register in one block. It adds internal load-use hazard detection with bubble insertion and a stall request to fetch. It also adds true hold semantics, EX→ID and WB→ID operand bypass, an ID/EX valid bit, and a saturating bubble counter. It sits between fetch (IF/ID) and execute, and reuses the team's regfile, control_unit and imm_gen.

Parameters:
XLEN, 32, datapath width (32 or 64); immediates sign-extended from 32 bits to XLEN.
NOP_INST, 32'h00000013, instruction word loaded into the ID/EX inst field on reset, flush and bubble.
CNT_W, 16, width of the bubble counter.
FWD_EN, 1, 1 enables the EX→ID bypass; 0 reads regfile/WB only.

Ports:
i_decode_clk  in  1  clock; all state updates on its rising edge
i_decode_reset  in  1  synchronous, active-high reset
i_decode_pc  in  XLEN  PC of the instruction in IF/ID
i_decode_inst  in  32  instruction in IF/ID
i_decode_inst_vld  in  1  IF/ID holds a real instruction
i_decode_rd_data / i_decode_rd_addr / i_decode_rd_wren  in  XLEN/5/1  writeback port
i_decode_flush  in  1  squash the instruction entering ID/EX
i_decode_hold  in  1  downstream stall: ID/EX keeps its contents
i_decode_alu_data_execute  in  XLEN  ALU result of the instruction currently in EX
i_decode_cnt_clr  in  1  synchronous clear of the bubble counter
o_decode_inst_ex, o_decode_pc_ex  out  32, XLEN  ID/EX instruction and PC
o_decode_rs1_data_ex, o_decode_rs2_data_ex, o_decode_imm_out_ex  out  XLEN  operands and immediate
o_decode_alu_op_ex 4, o_decode_br_un_ex 1, o_decode_asel_ex 1, o_decode_bsel_ex 1  out  execute control
o_decode_lsu_wren_ex 1, o_decode_slt_sl_ex 3  out  memory control
o_decode_wb_sel_ex 2, o_decode_rd_wren_ex 1  out  writeback control
o_insn_vld_ctrl  out  1  registered control_unit legality flag
o_decode_vld_ex  out  1  ID/EX holds a real instruction (0 = bubble)
o_decode_stall_req  out  1  combinational; fetch and IF/ID must hold this cycle
o_decode_rs1_addr_hazard, o_decode_rs2_addr_hazard  out  5  i_decode_inst[19:15], [24:20]
o_decode_bubble_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Latency: one cycle from IF/ID to ID/EX outputs. Regfile read is asynchronous; regfile write is synchronous; x0 always reads 0.
- "Cleared" ID/EX state: all data and control fields 0, inst = NOP_INST, o_decode_vld_ex = 0, o_insn_vld_ctrl = 1. Reset loads this state and sets the counter to 0.
- EX holds a load when: o_decode_vld_ex, o_decode_inst_ex[6:0] = 7'b0000011, and rd_ex = o_decode_inst_ex[11:7] ≠ 0.
- rs1_used: true unless the opcode is LUI, AUIPC or JAL.
- rs2_used: true only for the R-type, STORE and BRANCH opcodes.
- load_use: EX holds a load, i_decode_inst_vld = 1, and (rs1_used and rs1 = rd_ex, or rs2_used and rs2 = rd_ex).
- o_decode_stall_req = load_use AND NOT i_decode_flush.
- Per-edge priority:
  1. reset: cleared state.
  2. flush: cleared state.
  3. hold: every ID/EX field retained, including data, PC and valid.
  4. load_use: cleared state (bubble); counter increments.
  5. otherwise: capture decode results; o_decode_vld_ex = i_decode_inst_vld.
- Operand source per rs (rs ≠ 0), highest priority first:
  1. EX bypass, taken when FWD_EN = 1, o_decode_vld_ex = 1, o_decode_rd_wren_ex = 1, rd_ex = rs, and EX does not hold a load: use i_decode_alu_data_execute.
  2. WB write-through, taken when i_decode_rd_wren = 1 and i_decode_rd_addr = rs: use i_decode_rd_data.
  3. Regfile read.
  rs = 0 always yields 0.
- Bubble counter: i_decode_cnt_clr wins over increment; saturates at all-ones with no wrap; does not count flush or hold cycles.
- Stall and hold together: ID/EX holds; stall_req is still driven; the counter does not increment.
- The hazard address outputs are purely combinational from i_decode_inst.

Test Plan:
1. Reset asserted at an edge while ID/EX is mid-stream → next cycle: inst = 0x00000013, all data/control = 0, vld_ex = 0, insn_vld_ctrl = 1, bubble_cnt = 0.
2. lw x5,0(x1) in EX, then add x6,x5,x2 in decode → stall_req = 1 for exactly one cycle; ID/EX becomes a bubble; bubble_cnt = 1. Next cycle the add is captured with vld_ex = 1.
3. addi x7,x0,9 in EX (ALU result 9), add x8,x7,x7 in decode, regfile x7 = 0 → rs1_data = rs2_data = 9. Repeat with FWD_EN = 0 → both 0.
4. WB writes x3 = 0xDEAD_BEEF in the same cycle that decode reads x3 → rs1_data = 0xDEADBEEF. A WB write to x0 with value 5 → operand reads 0.
5. Hold for 3 cycles while IF/ID changes → all ID/EX outputs unchanged. Flush and load_use in the same cycle → cleared state, stall_req = 0, counter unchanged.
6. CNT_W = 2 with 5 consecutive load-use bubbles → counter reads 1, 2, 3, 3, 3. Clear and a bubble in the same cycle → 0.
